// File: rtl/adc_sar_sequencer.sv
// Sequences SAR ADC conversions (soc/eoc handshake), averages 2^k samples, and buffers results in a FIFO.
// All outputs registered; results drain via res_valid/res_ready and are dropped (overflow) when the FIFO is full.
module adc_sar_sequencer #(
  parameter int N            = 8,
  parameter int MAX_LOG2_AVG = 4,
  parameter int DEPTH        = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enable,
  input  logic         trigger,
  input  logic         continuous,
  input  logic [2:0]   avg_log2,
  input  logic         clr_flags,
  input  logic         eoc,
  input  logic         eoc_it,
  input  logic [N-1:0] dout,
  output logic         soc,
  output logic [N-1:0] res_data,
  output logic         res_valid,
  input  logic         res_ready,
  output logic         busy,
  output logic         overflow,
  output logic         timeout_err
);
  localparam int KW   = $clog2(MAX_LOG2_AVG + 1);
  localparam int CW   = MAX_LOG2_AVG + 1;
  localparam int AW   = $clog2(DEPTH);
  localparam int TW   = $clog2(TIMEOUT + 1);
  localparam int ACCW = N + MAX_LOG2_AVG;

  typedef enum logic [1:0] {IDLE, START, WAIT, PUSH} state_t;

  state_t          state, state_n;
  logic            soc_n, load_k, acc_clr, acc_add, tmr_load, tmr_dec, tout_set;
  logic [KW-1:0]   k, k_clamped;
  logic [ACCW-1:0] acc;
  logic [CW-1:0]   cnt, cnt_inc;
  logic            last;
  logic [TW-1:0]   tmr;

  logic [N-1:0]    mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
  logic [AW:0]     count, count_n;
  logic            full, push_req, push, pop, ovf_set;
  logic [N-1:0]    push_data, head_n;

  assign k_clamped = (32'(avg_log2) > 32'(MAX_LOG2_AVG)) ? KW'(MAX_LOG2_AVG) : KW'(avg_log2);
  assign cnt_inc   = cnt + 1'b1;
  assign last      = (cnt_inc == (CW'(1) << k));
  assign push_data = N'(acc >> k);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      soc   <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_n;
      soc   <= soc_n;
      busy  <= (state_n != IDLE);
    end
  end

  always_comb begin
    state_n  = state;
    soc_n    = 1'b0;
    load_k   = 1'b0;
    acc_clr  = 1'b0;
    acc_add  = 1'b0;
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;
    tout_set = 1'b0;
    if (!enable) begin
      // Abort from any state; a partial burst is thrown away.
      state_n = IDLE;
      acc_clr = 1'b1;
    end else begin
      case (state)
        IDLE: if (trigger) begin
          state_n = START;
          load_k  = 1'b1;
          acc_clr = 1'b1;
        end
        START: if (eoc) begin
          state_n  = WAIT;
          soc_n    = 1'b1;
          tmr_load = 1'b1;
        end
        WAIT: begin
          if (eoc_it) begin
            acc_add = 1'b1;
            state_n = last ? PUSH : START;
          end else if (tmr == '0) begin
            tout_set = 1'b1;
            acc_clr  = 1'b1;
            state_n  = IDLE;
          end else begin
            tmr_dec = 1'b1;
          end
        end
        PUSH: begin
          if (continuous) begin
            state_n = START;
            acc_clr = 1'b1;
          end else begin
            state_n = IDLE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      k           <= '0;
      acc         <= '0;
      cnt         <= '0;
      tmr         <= '0;
      overflow    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      if (load_k) k <= k_clamped;
      if (acc_clr) begin
        acc <= '0;
        cnt <= '0;
      end else if (acc_add) begin
        acc <= acc + ACCW'(dout);
        cnt <= cnt_inc;
      end
      if (tmr_load)     tmr <= TW'(TIMEOUT);
      else if (tmr_dec) tmr <= tmr - 1'b1;
      // A set in the same cycle as clr_flags takes priority.
      if (ovf_set)        overflow <= 1'b1;
      else if (clr_flags) overflow <= 1'b0;
      if (tout_set)       timeout_err <= 1'b1;
      else if (clr_flags) timeout_err <= 1'b0;
    end
  end

  // A full FIFO still accepts a push when the head is popped in the same cycle.
  assign push_req = (state == PUSH);
  assign pop      = res_valid & res_ready;
  assign full     = (count == (AW + 1)'(DEPTH));
  assign push     = push_req & (~full | pop);
  assign ovf_set  = push_req & full & ~res_ready;

  always_comb begin
    wr_ptr_n = push ? wr_ptr + 1'b1 : wr_ptr;
    rd_ptr_n = pop  ? rd_ptr + 1'b1 : rd_ptr;
    count_n  = count;
    if (push && !pop)      count_n = count + 1'b1;
    else if (pop && !push) count_n = count - 1'b1;
    // Registered head: bypass the entry being written when it becomes the head.
    if (count_n == '0)                   head_n = '0;
    else if (push && rd_ptr_n == wr_ptr) head_n = push_data;
    else                                 head_n = mem[rd_ptr_n];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
    end else begin
      wr_ptr    <= wr_ptr_n;
      rd_ptr    <= rd_ptr_n;
      count     <= count_n;
      res_valid <= (count_n != '0);
      res_data  <= head_n;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: tb/tb_adc_sar_sequencer.sv
// Directed bench for adc_sar_sequencer: the initial block plays the ADC and the result consumer.
module tb_adc_sar_sequencer;
  logic       clk, rst, enable, trigger, continuous, clr_flags, eoc, eoc_it, res_ready;
  logic [2:0] avg_log2;
  logic [7:0] dout, res_data;
  logic       soc, res_valid, busy, overflow, timeout_err;

  int checks  = 0;
  int errors  = 0;
  int soc_cnt = 0;
  int base, waited, n;
  logic [7:0] avg_vals [4] = '{8'd10, 8'd11, 8'd12, 8'd14};
  logic [7:0] ov_vals  [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
  logic [7:0] drain    [4] = '{8'h22, 8'h33, 8'h44, 8'h66};

  adc_sar_sequencer #(.N(8), .MAX_LOG2_AVG(4), .DEPTH(4), .TIMEOUT(20)) dut (
    .clk(clk), .rst(rst), .enable(enable), .trigger(trigger), .continuous(continuous),
    .avg_log2(avg_log2), .clr_flags(clr_flags), .eoc(eoc), .eoc_it(eoc_it), .dout(dout),
    .soc(soc), .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
    .busy(busy), .overflow(overflow), .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (soc) soc_cnt <= soc_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic trig(input logic [2:0] a);
    avg_log2 = a;
    trigger  = 1'b1;
    tick();
    trigger  = 1'b0;
  endtask

  task automatic wait_soc(output int w);
    w = 0;
    while (!soc && w < 60) begin
      tick();
      w++;
    end
    if (!soc) chk("soc_wait_expired", 32'(soc), 32'd1);
  endtask

  // Pulse eoc_it lat cycles from now; returns in the cycle after the pulse.
  task automatic finish_conv(input logic [7:0] v, input int lat);
    repeat (lat) tick();
    eoc_it = 1'b1;
    dout   = v;
    tick();
    eoc_it = 1'b0;
  endtask

  task automatic pop();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; enable = 1'b1; trigger = 1'b0; continuous = 1'b0; clr_flags = 1'b0;
    eoc = 1'b1; eoc_it = 1'b0; res_ready = 1'b0; avg_log2 = 3'd0; dout = 8'h00;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    chk("rst_soc", 32'(soc), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(res_valid), 32'd0);
    chk("rst_data", 32'(res_data), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_tout", 32'(timeout_err), 32'd0);

    // Single conversion, k=0
    base = soc_cnt;
    trig(3'd0);
    chk("trig_busy", 32'(busy), 32'd1);
    chk("trig_soc_early", 32'(soc), 32'd0);
    tick();
    chk("trig_soc", 32'(soc), 32'd1);
    tick();
    chk("soc_width", 32'(soc), 32'd0);
    finish_conv(8'h5A, 9);
    chk("single_push_valid", 32'(res_valid), 32'd0);
    chk("single_push_busy", 32'(busy), 32'd1);
    tick();
    chk("single_valid", 32'(res_valid), 32'd1);
    chk("single_data", 32'(res_data), 32'h5A);
    chk("single_busy_off", 32'(busy), 32'd0);
    chk("single_soc_count", 32'(soc_cnt - base), 32'd1);
    pop();
    chk("pop_empty_valid", 32'(res_valid), 32'd0);
    chk("pop_empty_data", 32'(res_data), 32'd0);

    // Averaging 4 samples: (10+11+12+14)>>2 = 11
    base = soc_cnt;
    trig(3'd2);
    for (int i = 0; i < 4; i++) begin
      wait_soc(waited);
      if (i > 0) chk("avg_soc_gap", 32'(waited), 32'd1);
      finish_conv(avg_vals[i], 3);
    end
    tick();
    chk("avg_valid", 32'(res_valid), 32'd1);
    chk("avg_data", 32'(res_data), 32'd11);
    chk("avg_soc_count", 32'(soc_cnt - base), 32'd4);
    pop();

    // avg_log2=7 clamps to 4: 16 samples i*16+15, sum 2160, result 135
    base = soc_cnt;
    trig(3'd7);
    avg_log2 = 3'd0;
    for (int i = 0; i < 16; i++) begin
      wait_soc(waited);
      finish_conv(8'(i * 16 + 15), 1);
    end
    tick();
    chk("clamp_data", 32'(res_data), 32'd135);
    chk("clamp_soc_count", 32'(soc_cnt - base), 32'd16);
    pop();

    // Overflow in continuous mode with consumer stalled
    continuous = 1'b1;
    trig(3'd0);
    for (int i = 0; i < 5; i++) begin
      wait_soc(waited);
      finish_conv(ov_vals[i], 2);
    end
    chk("ovf_full_valid", 32'(res_valid), 32'd1);
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    chk("ovf_set_wins", 32'(overflow), 32'd1);
    chk("ovf_head", 32'(res_data), 32'h11);
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    chk("ovf_clr", 32'(overflow), 32'd0);
    finish_conv(ov_vals[5], 2);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("full_pop_push_ovf", 32'(overflow), 32'd0);
    chk("full_pop_push_head", 32'(res_data), 32'h22);
    tick();
    chk("cont_restart_soc", 32'(soc), 32'd1);

    // Abort in WAIT; a late eoc_it must not restart anything
    continuous = 1'b0;
    enable = 1'b0;
    tick();
    base = soc_cnt;
    chk("abort_busy", 32'(busy), 32'd0);
    enable = 1'b1;
    eoc_it = 1'b1;
    dout = 8'h99;
    tick();
    eoc_it = 1'b0;
    repeat (3) tick();
    chk("late_eoc_busy", 32'(busy), 32'd0);
    chk("late_eoc_soc", 32'(soc_cnt - base), 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk("drain_valid", 32'(res_valid), 32'd1);
      chk("drain_data", 32'(res_data), 32'(drain[i]));
      pop();
    end
    chk("drain_empty", 32'(res_valid), 32'd0);

    // Timeout with one entry buffered
    trig(3'd0);
    wait_soc(waited);
    finish_conv(8'h77, 1);
    tick();
    trig(3'd0);
    wait_soc(waited);
    n = 0;
    while (!timeout_err && n < 40) begin
      tick();
      n++;
    end
    chk("tout_window", 32'(n >= 20 && n <= 22), 32'd1);
    chk("tout_flag", 32'(timeout_err), 32'd1);
    chk("tout_idle", 32'(busy), 32'd0);
    chk("tout_fifo_valid", 32'(res_valid), 32'd1);
    chk("tout_fifo_data", 32'(res_data), 32'h77);
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    chk("tout_clr", 32'(timeout_err), 32'd0);
    trig(3'd0);
    wait_soc(waited);
    finish_conv(8'h42, 1);
    tick();
    chk("after_tout_head", 32'(res_data), 32'h77);
    pop();
    chk("after_tout_next", 32'(res_data), 32'h42);
    pop();

    // ADC busy: eoc low holds the sequencer in START
    eoc = 1'b0;
    base = soc_cnt;
    trig(3'd0);
    repeat (5) tick();
    chk("eoc_hold_soc", 32'(soc_cnt - base), 32'd0);
    chk("eoc_hold_busy", 32'(busy), 32'd1);
    eoc = 1'b1;
    tick();
    chk("eoc_release_soc", 32'(soc), 32'd1);
    finish_conv(8'h3C, 2);
    tick();
    chk("eoc_release_data", 32'(res_data), 32'h3C);
    pop();

    // Reset while in WAIT with two entries buffered
    trig(3'd0);
    wait_soc(waited);
    finish_conv(8'hA1, 1);
    tick();
    trig(3'd0);
    wait_soc(waited);
    finish_conv(8'hA2, 1);
    tick();
    trig(3'd0);
    wait_soc(waited);
    repeat (2) tick();
    chk("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_soc", 32'(soc), 32'd0);
    chk("mid_rst_valid", 32'(res_valid), 32'd0);
    chk("mid_rst_data", 32'(res_data), 32'd0);
    chk("mid_rst_ovf", 32'(overflow), 32'd0);
    chk("mid_rst_tout", 32'(timeout_err), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/adc_sar_sequencer.md
# adc_sar_sequencer

Conversion sequencer and result buffer that sits directly downstream (and in control) of the SAR ADC controller. It issues `soc` pulses, collects `dout` on each `eoc_it`, averages 2^k conversions per result, and buffers results in a small FIFO drained through a valid/ready interface. It also detects a stalled converter with a timeout.

## Interface
- `N`, default 8: ADC result width.
- `MAX_LOG2_AVG`, default 4: largest averaging exponent supported.
- `DEPTH`, default 4: result FIFO depth; must be a power of 2 and at least 2.
- `TIMEOUT`, default 255: maximum number of cycles spent waiting for `eoc_it`.

Ports:
- `clk` in 1: single clock for the whole block.
- `rst` in 1: reset, synchronous, active-high.
- `enable` in 1: block enable; low aborts any burst.
- `trigger` in 1: starts a burst; sampled only in IDLE.
- `continuous` in 1: after each result, start the next burst automatically.
- `avg_log2` in 3: averaging exponent; the burst length is 2^`avg_log2` conversions.
- `clr_flags` in 1: clears `overflow` and `timeout_err`.
- `eoc` in 1: ADC idle level.
- `eoc_it` in 1: ADC end-of-conversion pulse.
- `dout` in N: ADC result.
- `soc` out 1: start-of-conversion pulse, exactly one cycle wide.
- `res_data` out N: FIFO head.
- `res_valid` out 1: FIFO is not empty.
- `res_ready` in 1: consumer pop.
- `busy` out 1: the state is not IDLE.
- `overflow` out 1: sticky; a result was dropped because the FIFO was full.
- `timeout_err` out 1: sticky; a burst was aborted by the timeout.

## Operation
- State machine states: IDLE, START, WAIT, PUSH.
- **IDLE**
  - When `enable` and `trigger` are both high, latch `avg_log2` into `k`. Values above `MAX_LOG2_AVG` clamp to `MAX_LOG2_AVG`.
  - Clear the accumulator and the sample count, then go to START.
- **START**
  - If `eoc`=1: assert `soc` for one cycle, load the timeout counter with `TIMEOUT`, and go to WAIT.
  - If `eoc`=0: hold in START with `soc`=0 and no time limit.
- **WAIT**
  - On `eoc_it`: `acc += dout`. The accumulator is N+MAX_LOG2_AVG bits wide and unsigned, so it cannot overflow.
  - Then increment the sample count. If count = 2^k, go to PUSH; otherwise go to START.
  - Without `eoc_it`, decrement the timeout counter. When it reaches 0, set `timeout_err`, discard the accumulator, and go to IDLE.
- **PUSH**
  - Compute the result as `acc >> k`, truncated (floor) to N bits.
  - Write the result into the FIFO. If the FIFO is full and `res_ready` is not asserted in the same cycle, drop the result and set `overflow`.
  - Next state: START (with a fresh accumulator and count) if `continuous`=1 and `enable`=1; otherwise IDLE.
- **FIFO**
  - Pop happens when `res_valid` and `res_ready` are both high.
  - Push and pop in the same cycle are always accepted, including when the FIFO is full. The occupancy is then unchanged.
  - Pointers wrap modulo `DEPTH`.
  - `res_data` is undefined-free: it shows 0 when the FIFO is empty.
- **Other rules**
  - `trigger` outside IDLE is ignored.
  - `eoc_it` outside WAIT is ignored.
  - `enable`=0 in any state forces IDLE on the next edge. The partial burst is discarded and `soc` is not issued. FIFO contents are kept.
  - If `clr_flags` and a new flag-set event occur in the same cycle, the set wins.

## Timing
- **Reset:** state=IDLE. `soc`, `busy`, `res_valid`, `overflow` and `timeout_err` are all 0. `res_data`=0. FIFO is empty, and the accumulator and all counters are 0.
- All outputs are registered.
- **Trigger to `soc`:** with `trigger` sampled high at edge T in IDLE, `busy` is 1 from T+1 and `soc` is high in cycle T+2, provided `eoc`=1.
- **Between conversions:** with `eoc_it` at cycle E (not the last sample), the next `soc` is high at E+2.
- **Last sample to output:** with `eoc_it` at cycle E on the last sample, the PUSH state occupies cycle E+1. `res_valid` rises at E+2 if the FIFO was empty.
- **Pop:** a pop at edge P presents the next entry at P+1 and deasserts `res_valid` at P+1 if the FIFO becomes empty.
- **Timeout:** the abort occurs `TIMEOUT`+1 cycles after `soc`. `timeout_err` and IDLE are both visible on the following cycle.

## Test plan
- **Single conversion:** k=0, `trigger` pulse, ADC model returns 0x5A with `eoc_it` 10 cycles after `soc` -> one `soc` pulse; `res_data`=0x5A with `res_valid` 2 cycles after `eoc_it`; `busy` returns to 0.
- **Averaging:** `avg_log2`=2, samples 10, 11, 12, 14 -> exactly 4 `soc` pulses; result 11 (sum 47, shifted right by 2); `avg_log2`=7 clamps to 4, giving 16 conversions.
- **Overflow:** `continuous`=1, `res_ready`=0, DEPTH=4 -> 4 results are buffered, the 5th is dropped and `overflow`=1. A `res_ready` held high during a PUSH into a full FIFO accepts the push with no overflow. `clr_flags` clears `overflow`.
- **Timeout:** TIMEOUT=20, ADC never pulses `eoc_it` -> `timeout_err`=1 and IDLE within 22 cycles of `soc`; FIFO is unchanged; the next trigger works normally.
- **Abort and busy ADC:** `enable` dropped mid-burst -> IDLE next cycle, no further `soc`, and a late `eoc_it` is ignored. `eoc`=0 held in START -> no `soc` until `eoc`=1.
- **Reset mid-burst:** `rst` asserted while in WAIT with 2 entries in the FIFO -> all outputs at their reset values on the next cycle and `res_valid`=0.
